alu_iterative: RTL and testbench
================================

# alu_iterative

Parametrised successor to the single-cycle datapath ALU. It executes one opcode-selected operation per start handshake. Logic and add/sub ops complete in one cycle; multiply (shift-add) and divide (restoring) iterate one bit per cycle. It sits between the BR/ACC registers and the ACC/MR/DR write-back path of the CPU datapath, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 16: operand/result width, ≥ 2.
- `CNTW`, $clog2(WIDTH+1): iteration counter width (derived, not overridden).
- `clk`  in  1  rising-edge clock; the block uses one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only when idle.
- `op`  in  4  opcode, sampled with `start`.
- `acc_in`  in  WIDTH  operand A, sampled with `start`.
- `br_in`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `acc_out`  out  WIDTH  low result / quotient.
- `mr_out`  out  WIDTH  high product half.
- `dr_out`  out  WIDTH  remainder.
- `zero`, `carry`, `div_zero`  out  1 each  status flags, valid from `done` onward.

## Operation
- Opcodes: 0 CLR, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT (~A), 6 SHL (A<<1), 7 SHR (A>>1, logical), 8 MUL (unsigned), 9 DIV (unsigned). Codes 10–15 are NOP: `done` pulses and all results and flags are held.
- States: IDLE, ITER, FIN.
  - IDLE with `start`: operands are latched.
  - Single-cycle ops and DIV with B = 0 write results at that edge and go to FIN.
  - MUL and DIV with B ≠ 0 load counter = WIDTH and go to ITER.
- ITER: one step per edge and the counter decrements. On the step where the counter reaches 0, results are written and the state goes to FIN.
  - MUL: if the multiplier LSB is set, add the multiplicand to the upper partial; then shift the {upper, lower} pair right. The 2·WIDTH product goes to {`mr_out`, `acc_out`}.
  - DIV: shift {rem, quot} left, trial-subtract B, keep the result if non-negative, and set the quotient bit.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- Write rules:
  - CLR zeroes `acc_out`, `mr_out`, `dr_out` and all flags.
  - ADD through SHR write `acc_out` only. `mr_out` and `dr_out` are held.
  - MUL writes `acc_out` and `mr_out`. DIV writes `acc_out` and `dr_out`.
- `carry`:
  - ADD: carry-out.
  - SUB: borrow (1 when A < B).
  - SHL: the shifted-out A[WIDTH-1]. SHR: the shifted-out A[0].
  - All other ops: 0.
- `zero`: `acc_out` == 0, except for MUL, where it is set when the full product == 0.
- DIV with B = 0: `acc_out` = all ones, `dr_out` = A, `div_zero` = 1. `div_zero` is 0 for every other op.

## Timing
- `rst` at an edge sets state to IDLE and all outputs to 0, including `busy` and `done`.
  - `rst` mid-ITER aborts the operation: no `done` pulse, and results are not written.
  - `rst` wins over a simultaneous `start`.
- Single-cycle ops: start at edge 0, `busy` and `done` high in cycle 1, results visible in cycle 1.
- MUL and DIV (B ≠ 0): start at edge 0.
  - `busy` is high for cycles 1..WIDTH+1.
  - Results are written at edge WIDTH.
  - `done` is high in cycle WIDTH+1.
  - Latency is WIDTH+1 cycles from the start edge to `done`.
- `busy` is 1 in ITER and FIN and 0 in IDLE.
- `start` is ignored while `busy`=1. `start` in the same cycle as `done` is also ignored, so back-to-back ops need `start` held into the IDLE cycle.
- Results are stable from `done` until the next op writes them. Intermediate ITER values never appear on the outputs.

## Structure
- Package `alu_pkg`: opcode localparams/enum, state enum `alu_state_t`.
- Sub-module `alu_muldiv_step`: combinational single-iteration datapath (MUL add-shift / DIV shift-subtract), parametrised by WIDTH. The FSM, counter and registers stay in `alu_iterative`.

## Test plan
- ADD, 0xFFFF + 0x0001 -> `acc_out`=0x0000, `carry`=1, `zero`=1, `done` in cycle 1, `mr_out` and `dr_out` unchanged.
- MUL, 0x1234 × 0x5678 -> `mr_out`=0x0626, `acc_out`=0x0060, `done` exactly in cycle 17, `busy` high for cycles 1–17.
- DIV, 100 ÷ 7 -> `acc_out`=0x000E, `dr_out`=0x0002, `div_zero`=0, `done` in cycle 17. DIV, 0x1234 ÷ 0 -> `acc_out`=0xFFFF, `dr_out`=0x1234, `div_zero`=1, `done` in cycle 1.
- SHR 0x0001 -> `acc_out`=0, `carry`=1, `zero`=1. SUB 3 − 5 -> `acc_out`=0xFFFE, `carry`=1. Opcode 12 -> `done` pulses, outputs unchanged.
- Pulse `start` with a new op during the 5th MUL cycle -> ignored, and the original product completes. `rst` at cycle 8 of a MUL -> no `done`, all outputs 0, and the next ADD is accepted.
- Parameter sweep WIDTH=8 and 32: 200 random MUL/DIV ops checked against a reference model, with `done` at cycle WIDTH+1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state type shared by the iterative ALU.
// Imported by alu_iterative and alu_muldiv_step.
package alu_pkg;

    localparam logic [3:0] OP_CLR = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIN
    } alu_state_t;

endpackage

// File: rtl/alu_muldiv_step.sv
// alu_muldiv_step: one combinational MUL add-shift / DIV shift-subtract step.
// Ports: is_div, hi/lo partials, opnd (multiplicand or divisor) -> hi_nxt/lo_nxt.
module alu_muldiv_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rsh  = {hi, lo[WIDTH-1]};
        // rem < divisor before the shift, so any kept difference fits WIDTH bits
        diff = rsh[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (rsh >= {1'b0, opnd}) begin
                hi_nxt = diff;
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = rsh[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // carry out of the add shifts into the top of the upper half
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_iterative.sv
// alu_iterative: opcode-driven ALU; logic/add ops in one cycle, MUL/DIV iterate.
// Ports: start/op/acc_in/br_in in; busy, done, acc/mr/dr results and flags out.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] br_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] mr_out,
    output logic [WIDTH-1:0] dr_out,
    output logic             zero,
    output logic             carry,
    output logic             div_zero
);

    localparam int CNTW = $clog2(WIDTH + 1);

    alu_state_t       state, state_nxt;
    logic [CNTW-1:0]  cnt;
    logic             div_q;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_op;
    logic             iter_op;
    logic             last;

    alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (div_q),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    assign sc_op   = (op >= OP_ADD) && (op <= OP_SHR);
    assign iter_op = (op == OP_MUL) ||
                     ((op == OP_DIV) && (br_in != '0));
    assign last    = (state == S_ITER) && (cnt == CNTW'(1));
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = iter_op ? S_ITER : S_FIN;
            S_ITER: if (last)  state_nxt = S_FIN;
            S_FIN:             state_nxt = S_IDLE;
            default:           state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        case (op)
            OP_ADD: {sc_carry, sc_res} = {1'b0, acc_in} + {1'b0, br_in};
            OP_SUB: {sc_carry, sc_res} = {1'b0, acc_in} - {1'b0, br_in};
            OP_AND: sc_res = acc_in & br_in;
            OP_OR:  sc_res = acc_in | br_in;
            OP_NOT: sc_res = ~acc_in;
            OP_SHL: begin
                sc_res   = {acc_in[WIDTH-2:0], 1'b0};
                sc_carry = acc_in[WIDTH-1];
            end
            OP_SHR: begin
                sc_res   = {1'b0, acc_in[WIDTH-1:1]};
                sc_carry = acc_in[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_q    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            acc_out  <= '0;
            mr_out   <= '0;
            dr_out   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == S_IDLE && start) begin
            cnt   <= CNTW'(WIDTH);
            div_q <= (op == OP_DIV);
            hi    <= '0;
            // MUL: lo = multiplier, opnd = multiplicand; DIV: lo = dividend
            lo    <= (op == OP_DIV) ? acc_in : br_in;
            opnd  <= (op == OP_DIV) ? br_in : acc_in;
            if (op == OP_CLR) begin
                acc_out  <= '0;
                mr_out   <= '0;
                dr_out   <= '0;
                zero     <= 1'b0;
                carry    <= 1'b0;
                div_zero <= 1'b0;
            end else if (sc_op) begin
                acc_out  <= sc_res;
                zero     <= (sc_res == '0);
                carry    <= sc_carry;
                div_zero <= 1'b0;
            end else if (op == OP_DIV && br_in == '0) begin
                acc_out  <= '1;
                dr_out   <= acc_in;
                zero     <= 1'b0;
                carry    <= 1'b0;
                div_zero <= 1'b1;
            end
        end else if (state == S_ITER) begin
            cnt <= cnt - CNTW'(1);
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            if (last) begin
                acc_out  <= lo_nxt;
                carry    <= 1'b0;
                div_zero <= 1'b0;
                if (div_q) begin
                    dr_out <= hi_nxt;
                    zero   <= (lo_nxt == '0);
                end else begin
                    mr_out <= hi_nxt;
                    zero   <= ({hi_nxt, lo_nxt} == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: directed checks at WIDTH=16 plus MUL/DIV sweep at 8 and 32.
// Drives and samples on the falling edge; cycle k is the cycle after edge k.
module tb_alu_iterative;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [15:0] acc_in, br_in;
    logic        busy, done, zero, carry, div_zero;
    logic [15:0] acc_out, mr_out, dr_out;

    logic        st_s;
    logic [3:0]  op_s;
    logic [31:0] a_s, b_s;
    logic        busy8, done8, z8, c8, dz8;
    logic [7:0]  acc8, mr8, dr8;
    logic        busy32, done32, z32, c32, dz32;
    logic [31:0] acc32, mr32, dr32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_iterative #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .acc_in(acc_in), .br_in(br_in), .busy(busy), .done(done),
        .acc_out(acc_out), .mr_out(mr_out), .dr_out(dr_out),
        .zero(zero), .carry(carry), .div_zero(div_zero)
    );

    alu_iterative #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st_s), .op(op_s),
        .acc_in(a_s[7:0]), .br_in(b_s[7:0]), .busy(busy8), .done(done8),
        .acc_out(acc8), .mr_out(mr8), .dr_out(dr8),
        .zero(z8), .carry(c8), .div_zero(dz8)
    );

    alu_iterative #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(st_s), .op(op_s),
        .acc_in(a_s), .br_in(b_s), .busy(busy32), .done(done32),
        .acc_out(acc32), .mr_out(mr32), .dr_out(dr32),
        .zero(z32), .carry(c32), .div_zero(dz32)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inj: cycle in which a stray ADD start is pulsed; rc: reset cycle
    task automatic run16(input logic [3:0] o, input logic [15:0] a, b,
                         input int inj, input int rc,
                         output int dc, output int bc);
        @(negedge clk);
        op = o; acc_in = a; br_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = 0;
        bc = 0;
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            if (busy) bc++;
            if (done) dc = c;
            if (dc == 0) begin
                start = (c == inj);
                if (c == inj) begin
                    op = OP_ADD; acc_in = 16'h0001; br_in = 16'h0001;
                end
                rst = (c == rc);
                @(negedge clk);
            end
        end
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic res16(input string tag, input logic [15:0] ea, em, ed,
                         input logic ez, ec, edz);
        check({tag, ".acc"}, acc_out, ea);
        check({tag, ".mr"}, mr_out, em);
        check({tag, ".dr"}, dr_out, ed);
        check({tag, ".zero"}, zero, ez);
        check({tag, ".carry"}, carry, ec);
        check({tag, ".dz"}, div_zero, edz);
    endtask

    task automatic sweep(input int n);
        logic [63:0] e_lo32, e_hi32;
        logic [15:0] p8;
        logic [7:0]  e_lo8, e_hi8;
        logic [7:0]  a8, b8;
        int d8, d32, x8, x32;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op_s = ($urandom_range(1) == 0) ? OP_MUL : OP_DIV;
            a_s  = $urandom;
            b_s  = $urandom;
            if (i % 4 == 1) b_s = b_s & 32'h0000_000f;
            if (i % 16 == 3) b_s = 32'h0;
            a8 = a_s[7:0];
            b8 = b_s[7:0];
            if (op_s == OP_MUL) begin
                p8 = {8'h0, a8} * {8'h0, b8};
                e_lo8 = p8[7:0];
                e_hi8 = p8[15:8];
                e_lo32 = ({32'h0, a_s} * {32'h0, b_s}) & 64'hffff_ffff;
                e_hi32 = ({32'h0, a_s} * {32'h0, b_s}) >> 32;
                x8 = 9;
                x32 = 33;
            end else begin
                e_lo8  = (b8 == 0) ? 8'hff : a8 / b8;
                e_hi8  = (b8 == 0) ? a8 : a8 % b8;
                e_lo32 = (b_s == 0) ? 64'hffff_ffff : {32'h0, a_s / b_s};
                e_hi32 = (b_s == 0) ? {32'h0, a_s} : {32'h0, a_s % b_s};
                x8  = (b8 == 0) ? 1 : 9;
                x32 = (b_s == 0) ? 1 : 33;
            end
            st_s = 1'b1;
            @(negedge clk);
            st_s = 1'b0;
            d8 = 0;
            d32 = 0;
            for (int c = 1; c <= 40 && d32 == 0; c++) begin
                if (done8 && d8 == 0) d8 = c;
                if (done32) d32 = c;
                if (d32 == 0) @(negedge clk);
            end
            check("w8.cyc", d8, x8);
            check("w8.lo", acc8, e_lo8);
            check("w8.hi", (op_s == OP_MUL) ? mr8 : dr8, e_hi8);
            check("w32.cyc", d32, x32);
            check("w32.lo", acc32, e_lo32);
            check("w32.hi", (op_s == OP_MUL) ? mr32 : dr32, e_hi32);
        end
    endtask

    int dc, bc;

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; acc_in = '0; br_in = '0;
        st_s = 1'b0; op_s = '0; a_s = '0; b_s = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        res16("rst", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run16(OP_MUL, 16'h1234, 16'h5678, 0, 0, dc, bc);
        check("mul.cyc", dc, 17);
        check("mul.busy", bc, 17);
        res16("mul", 16'h0060, 16'h0626, 16'h0, 1'b0, 1'b0, 1'b0);

        run16(OP_DIV, 16'd100, 16'd7, 0, 0, dc, bc);
        check("div.cyc", dc, 17);
        res16("div", 16'h000e, 16'h0626, 16'h0002, 1'b0, 1'b0, 1'b0);

        run16(OP_ADD, 16'hffff, 16'h0001, 0, 0, dc, bc);
        check("add.cyc", dc, 1);
        check("add.busy", bc, 1);
        res16("add", 16'h0000, 16'h0626, 16'h0002, 1'b1, 1'b1, 1'b0);

        run16(OP_SUB, 16'd3, 16'd5, 0, 0, dc, bc);
        res16("sub", 16'hfffe, 16'h0626, 16'h0002, 1'b0, 1'b1, 1'b0);

        run16(OP_SHR, 16'h0001, 16'h0, 0, 0, dc, bc);
        res16("shr", 16'h0000, 16'h0626, 16'h0002, 1'b1, 1'b1, 1'b0);

        run16(4'd12, 16'h5555, 16'h3333, 0, 0, dc, bc);
        check("nop.cyc", dc, 1);
        res16("nop", 16'h0000, 16'h0626, 16'h0002, 1'b1, 1'b1, 1'b0);

        run16(OP_DIV, 16'h1234, 16'h0, 0, 0, dc, bc);
        check("dz.cyc", dc, 1);
        res16("dz", 16'hffff, 16'h0626, 16'h1234, 1'b0, 1'b0, 1'b1);

        run16(OP_SHL, 16'h8001, 16'h0, 0, 0, dc, bc);
        res16("shl", 16'h0002, 16'h0626, 16'h1234, 1'b0, 1'b1, 1'b0);

        run16(OP_NOT, 16'h00ff, 16'h0, 0, 0, dc, bc);
        check("not.acc", acc_out, 16'hff00);
        run16(OP_AND, 16'hf0f0, 16'h3c3c, 0, 0, dc, bc);
        check("and.acc", acc_out, 16'h3030);
        run16(OP_OR, 16'hf0f0, 16'h3c3c, 0, 0, dc, bc);
        check("or.acc", acc_out, 16'hfcfc);

        run16(OP_MUL, 16'h00ff, 16'h0101, 5, 0, dc, bc);
        check("inj.cyc", dc, 17);
        res16("inj", 16'hffff, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);

        run16(OP_MUL, 16'h8000, 16'h0002, 0, 0, dc, bc);
        res16("mulz", 16'h0000, 16'h0001, 16'h1234, 1'b0, 1'b0, 1'b0);
        run16(OP_MUL, 16'h0000, 16'h1234, 0, 0, dc, bc);
        res16("mul0", 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0);

        run16(OP_CLR, 16'h1111, 16'h2222, 0, 0, dc, bc);
        res16("clr", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        run16(OP_DIV, 16'd100, 16'd7, 0, 0, dc, bc);
        run16(OP_MUL, 16'h1234, 16'h5678, 0, 8, dc, bc);
        check("abort.done", dc, 0);
        check("abort.busy", busy, 1'b0);
        res16("abort", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        run16(OP_ADD, 16'd2, 16'd3, 0, 0, dc, bc);
        check("post.cyc", dc, 1);
        check("post.acc", acc_out, 16'd5);

        sweep(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
